// File: rtl/mul_share_sched.sv
// mul_share_sched
// Shares one sequential 8x8 multiplier among N_REQ requesters. A requester is
// picked round-robin, its operands are latched and the multiplier is started
// with a one-cycle pulse. The multiplier's done level is then followed through
// its drop (ack) and re-rise (finished). The product and the requester ID are
// returned on a valid/ready response port. Each wait phase is bounded by TMO,
// and an expired phase returns an error response with a zero product.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a/req_b           packed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_p/rsp_err  served requester, product, timeout flag
//   mul_st/mul_a/mul_b    start pulse and operands to the multiplier
//   mul_done/mul_p        multiplier done level (1 = idle/finished), product
//   busy                  high whenever the scheduler is not idle
module mul_share_sched #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int TMO   = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [8*N_REQ-1:0] req_a,
   input  logic [8*N_REQ-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [15:0]        rsp_p,
   output logic               rsp_err,
   output logic               mul_st,
   output logic [7:0]         mul_a,
   output logic [7:0]         mul_b,
   input  logic               mul_done,
   input  logic [15:0]        mul_p,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      RESP
   } state_t;

   localparam logic [7:0] TMO_LIM = 8'(TMO);

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]      mul_a_q, mul_a_d;
   logic [7:0]      mul_b_q, mul_b_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [15:0]     rsp_p_q, rsp_p_d;
   logic            rsp_err_q, rsp_err_d;
   logic [7:0]      tmo_cnt_q, tmo_cnt_d;

   logic [7:0]       op_a [N_REQ];
   logic [7:0]       op_b [N_REQ];
   logic             grant_found;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  scan_id;
   logic [N_REQ-1:0] grant_oh;
   logic [7:0]       grant_a;
   logic [7:0]       grant_b;

   // Unpack the flat operand buses so a requester's operands can be picked
   // with a plain array index instead of a variable part-select.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         op_a[i] = req_a[8*i +: 8];
         op_b[i] = req_b[8*i +: 8];
      end
   end

   // Round-robin arbiter: scan from rr_ptr upwards (wrapping) and take the
   // first requester with valid set. The rotated index is always below N_REQ,
   // so non-power-of-two requester counts never touch a missing slot.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_id     = '0;
      grant_oh    = '0;
      grant_a     = '0;
      grant_b     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_id = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!grant_found && req_valid[scan_id]) begin
            grant_found       = 1'b1;
            grant_id          = scan_id;
            grant_oh[scan_id] = 1'b1;
            grant_a           = op_a[scan_id];
            grant_b           = op_b[scan_id];
         end
      end
   end

   // Next-state and datapath logic. Everything holds by default; each state
   // only overrides what it changes. A timeout in either wait phase lands in
   // RESP with a zero product and the error flag set, so the requester always
   // gets exactly one answer per grant.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      rsp_id_d  = rsp_id_q;
      rsp_p_d   = rsp_p_q;
      rsp_err_d = rsp_err_q;
      tmo_cnt_d = tmo_cnt_q;
      req_ready = '0;

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               req_ready = grant_oh;
               mul_a_d   = grant_a;
               mul_b_d   = grant_b;
               rsp_id_d  = grant_id;
               rr_ptr_d  = ID_W'((int'(grant_id) + 1) % N_REQ);
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            tmo_cnt_d = '0;
            state_d   = WAIT_ACK;
         end

         // The multiplier acknowledges a start by dropping done. A done level
         // seen during ISSUE is stale and deliberately not looked at.
         WAIT_ACK: begin
            if (!mul_done) begin
               tmo_cnt_d = '0;
               state_d   = WAIT_DONE;
            end else if (tmo_cnt_q == TMO_LIM) begin
               rsp_p_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         WAIT_DONE: begin
            if (mul_done) begin
               rsp_p_d   = mul_p;
               rsp_err_d = 1'b0;
               state_d   = RESP;
            end else if (tmo_cnt_q == TMO_LIM) begin
               rsp_p_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         // Arbitration only resumes in the IDLE cycle after the handshake.
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset wins over everything, including an
   // in-flight multiply or a pending response; the multiplier itself is left
   // alone and simply finishes on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         rsp_id_q  <= '0;
         rsp_p_q   <= '0;
         rsp_err_q <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         rsp_id_q  <= rsp_id_d;
         rsp_p_q   <= rsp_p_d;
         rsp_err_q <= rsp_err_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // Status outputs decode directly from the registered state, so they are
   // glitch-free and drop the cycle after reset.
   assign mul_st    = (state_q == ISSUE);
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched
// Directed bench for mul_share_sched. A small behavioural multiplier model
// answers start pulses (normal, stuck-high or stuck-low done). Expected
// responses are queued when requests are driven and popped when the DUT
// presents a response.
module tb_mul_share_sched;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int TMO   = 15;

   localparam int MODE_NORMAL   = 0;
   localparam int MODE_STUCK_HI = 1;
   localparam int MODE_STUCK_LO = 2;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [15:0]     p;
      logic            err;
   } sb_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [8*N_REQ-1:0] req_a;
   logic [8*N_REQ-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [15:0]        rsp_p;
   logic               rsp_err;
   logic               mul_st;
   logic [7:0]         mul_a;
   logic [7:0]         mul_b;
   logic               mul_done = 1'b1;
   logic [15:0]        mul_p = '0;
   logic               busy;

   sb_t        sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         mdl_mode = MODE_NORMAL;
   int         mdl_delay = 4;
   int         mdl_cnt = 0;
   logic [15:0] mdl_prod = '0;

   mul_share_sched #(
      .N_REQ(N_REQ),
      .ID_W (ID_W),
      .TMO  (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_p    (rsp_p),
      .rsp_err  (rsp_err),
      .mul_st   (mul_st),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_done (mul_done),
      .mul_p    (mul_p),
      .busy     (busy)
   );

   // Free-running clock and cycle counter used for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural multiplier: a start drops done on the next cycle and done
   // rises mdl_delay cycles after that with the product. Stuck-high ignores
   // starts; stuck-low drops done and never raises it until released.
   always @(posedge clk) begin
      if (mul_st && mdl_mode != MODE_STUCK_HI) begin
         mul_done <= 1'b0;
         mdl_cnt  <= mdl_delay;
         mdl_prod <= {8'd0, mul_a} * {8'd0, mul_b};
      end else if (!mul_done && mdl_mode == MODE_NORMAL) begin
         if (mdl_cnt <= 1) begin
            mul_done <= 1'b1;
            mul_p    <= mdl_prod;
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic syncDrive();
      @(posedge clk);
      #1;
   endtask

   // Present a request and queue the response it should produce.
   task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b, input logic err);
      sb_t e;
      req_valid[id]     = 1'b1;
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
      e.id  = ID_W'(id);
      e.err = err;
      e.p   = err ? 16'h0000 : ({8'd0, a} * {8'd0, b});
      sb.push_back(e);
   endtask

   // Wait (bounded) for req_ready, check the grant, then let the edge take it.
   task automatic grabGrant(input int id, input logic [N_REQ-1:0] clr_mask, output int gcyc);
      int n = 0;
      while (req_ready == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("grant%0d", id), 32'(req_ready), 32'(1 << id));
      gcyc = cyc;
      syncDrive();
      req_valid = req_valid & ~clr_mask;
   endtask

   task automatic issueReq(input int id, input logic [7:0] a, input logic [7:0] b, input logic err, output int gcyc);
      syncDrive();
      applyStimulus(id, a, b, err);
      @(negedge clk);
      grabGrant(id, N_REQ'(1 << id), gcyc);
      @(negedge clk);
      checkOutput("st_pulse", 32'(mul_st), 1);
      checkOutput("mul_a", 32'(mul_a), 32'(a));
      checkOutput("mul_b", 32'(mul_b), 32'(b));
      checkOutput("busy_issue", 32'(busy), 1);
      checkOutput("ready_issue", 32'(req_ready), 0);
      @(negedge clk);
      checkOutput("st_single", 32'(mul_st), 0);
   endtask

   // Wait for a response, compare it with the scoreboard head, optionally
   // hold it under backpressure, and check rsp_valid drops after handshake.
   task automatic waitResp(input int hold, output int scyc);
      sb_t e;
      int  n = 0;
      scyc = -1;
      @(negedge clk);
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rsp_valid", 32'(rsp_valid), 1);
      checkOutput("sb_pending", 32'(sb.size() != 0), 1);
      if (rsp_valid && sb.size() != 0) begin
         scyc = cyc;
         e = sb.pop_front();
         checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
         checkOutput("rsp_p", 32'(rsp_p), 32'(e.p));
         checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 1);
            checkOutput("hold_id", 32'(rsp_id), 32'(e.id));
            checkOutput("hold_p", 32'(rsp_p), 32'(e.p));
            checkOutput("hold_ready", 32'(req_ready), 0);
         end
         if (hold > 0) begin
            syncDrive();
            rsp_ready = 1'b1;
            @(negedge clk);
         end
         @(negedge clk);
         checkOutput("rsp_drop", 32'(rsp_valid), 0);
      end
   endtask

   task automatic applyReset();
      syncDrive();
      rst = 1'b1;
      syncDrive();
      rst = 1'b0;
   endtask

   // Directed sequence: reset, single request, round-robin, backpressure,
   // both timeout phases and reset in the middle of a multiply.
   initial begin
      int gcyc;
      int scyc;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_ready", 32'(req_ready), 0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("rst_st", 32'(mul_st), 0);
      checkOutput("rst_mul_ab", 32'({mul_a, mul_b}), 0);
      checkOutput("rst_rsp", 32'({rsp_id, rsp_p, rsp_err}), 0);

      $display("[TB] single request");
      mdl_delay = 4;
      issueReq(1, 8'hFF, 8'hFF, 1'b0, gcyc);
      waitResp(0, scyc);
      checkOutput("t1_latency", 32'(scyc - gcyc), 7);

      $display("[TB] round-robin");
      applyReset();
      mdl_delay = 2;
      syncDrive();
      for (int i = 0; i < N_REQ; i++) applyStimulus(i, 8'(i + 1), 8'd3, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         grabGrant(k % N_REQ, (k == 4) ? '1 : '0, gcyc);
         if (k == 0) applyStimulus(0, 8'd1, 8'd3, 1'b0);
         waitResp(0, scyc);
      end

      $display("[TB] backpressure");
      mdl_delay = 3;
      rsp_ready = 1'b0;
      issueReq(2, 8'h12, 8'h34, 1'b0, gcyc);
      syncDrive();
      applyStimulus(3, 8'h0A, 8'h0B, 1'b0);
      waitResp(10, scyc);
      checkOutput("t3_regrant", 32'(req_ready), 32'h8);
      grabGrant(3, N_REQ'(4'b1000), gcyc);
      waitResp(0, scyc);

      $display("[TB] ack-phase timeout");
      mdl_mode = MODE_STUCK_HI;
      issueReq(0, 8'd5, 8'd6, 1'b1, gcyc);
      waitResp(0, scyc);
      checkOutput("t4_latency", 32'(scyc - gcyc), 18);
      mdl_mode = MODE_NORMAL;
      issueReq(1, 8'd7, 8'd9, 1'b0, gcyc);
      waitResp(0, scyc);

      $display("[TB] done-phase timeout");
      mdl_mode = MODE_STUCK_LO;
      issueReq(2, 8'h11, 8'h22, 1'b1, gcyc);
      waitResp(0, scyc);
      checkOutput("t5_latency", 32'(scyc - gcyc), 19);
      mdl_mode = MODE_NORMAL;
      for (int n = 0; n < 40 && !mul_done; n++) @(negedge clk);

      $display("[TB] reset mid-operation");
      mdl_delay = 8;
      issueReq(2, 8'd3, 8'd4, 1'b0, gcyc);
      syncDrive();
      rst = 1'b1;
      syncDrive();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_busy", 32'(busy), 0);
      checkOutput("t6_st", 32'(mul_st), 0);
      checkOutput("t6_rsp_valid", 32'(rsp_valid), 0);
      sb.delete();
      for (int n = 0; n < 40 && !mul_done; n++) @(negedge clk);
      syncDrive();
      applyStimulus(0, 8'd20, 8'd30, 1'b0);
      applyStimulus(3, 8'd2, 8'd50, 1'b0);
      @(negedge clk);
      grabGrant(0, N_REQ'(4'b0001), gcyc);
      waitResp(0, scyc);
      grabGrant(3, N_REQ'(4'b1000), gcyc);
      waitResp(0, scyc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
Scheduler that shares one sequential 8x8 multiplier unit among N_REQ requesters. It selects a requester round-robin, latches that requester's operands, and pulses the unit's start input. It then tracks the unit's done level through the drop and the re-rise, and returns the 16-bit product with the requester ID on a valid/ready response port. The block sits between the requester fabric and the multiplier instance and is the only driver of the multiplier's st/operand inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID (ceil(log2(N_REQ)), min 1)
TMO, 15, max wait cycles per multiplier phase before timeout (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_a  in  8*N_REQ  operand A, requester i at bits [8i+7:8i]
req_b  in  8*N_REQ  operand B, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  ID of the served requester
rsp_p  out  16  product (0 on error)
rsp_err  out  1  1 = multiplier timeout
mul_st  out  1  start pulse to the multiplier
mul_a  out  8  operand A to the multiplier
mul_b  out  8  operand B to the multiplier
mul_done  in  1  multiplier done level: 1 = idle/finished, 0 = computing
mul_p  in  16  multiplier product
busy  out  1  high when state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Reset is sampled on a clk edge, not asynchronous.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, mul_st=0, mul_a=0, mul_b=0, busy=0, tmo_cnt=0.
- Reset mid-operation: rst has priority over everything, including an in-flight multiply or a pending response. The response is dropped, rr_ptr returns to 0, mul_st is low from the next cycle, and the multiplier's own state is not touched.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE, no req_valid set: remain in IDLE.
- IDLE, any req_valid set:
  - Grant g = first set index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - At the edge: latch req_a[g]/req_b[g] into mul_a/mul_b, latch g into rsp_id, set rr_ptr = (g+1) mod N_REQ, go to ISSUE.
- req_ready is 0 in every state other than IDLE. A requester must hold valid and operands stable until it sees ready.
- ISSUE: mul_st=1 for exactly this one cycle. tmo_cnt is cleared; go to WAIT_ACK.
- mul_a/mul_b are held stable from ISSUE through the end of WAIT_DONE.
- WAIT_ACK:
  - mul_done==0: clear tmo_cnt, go to WAIT_DONE.
  - Else, tmo_cnt==TMO: timeout.
  - Else: tmo_cnt++.
- WAIT_DONE:
  - mul_done==1: register rsp_p=mul_p, rsp_err=0, go to RESP.
  - Else, tmo_cnt==TMO: timeout.
  - Else: tmo_cnt++.
- Timeout: register rsp_p=0 and rsp_err=1, go to RESP. Each wait state therefore lasts at most TMO+1 cycles.
- RESP:
  - rsp_valid=1; rsp_id, rsp_p and rsp_err are held stable.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid is 0 from the next cycle.
  - Arbitration resumes in the following IDLE cycle (no same-cycle re-grant).
- Latency: accept at cycle T, mul_st at T+1. With the multiplier dropping done at T+2 and raising it D cycles later, rsp_valid is first high at T+D+3.
- Fairness: with all requesters continuously valid, grants rotate strictly 0,1,2,...,N_REQ-1,0.
- Arithmetic: the product is passed through unmodified. The block performs no widening, truncation or rounding.
- A mul_done rise seen during ISSUE is ignored; only the WAIT_ACK→WAIT_DONE order counts.

Test Plan:
1. Single request: req_valid=4'b0010, a=8'hFF, b=8'hFF; model drops done 1 cycle after st and raises it 4 cycles later -> req_ready=4'b0010 for one cycle; mul_st pulse one cycle later; rsp_valid with rsp_id=1, rsp_p=16'hFE01, rsp_err=0 at T+7.
2. Round-robin: all 4 requesters hold valid with a=i+1, b=3, rsp_ready=1 -> grant order 0,1,2,3,0; products 3,6,9,12,3; no requester granted twice before all others have been granted.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_p stay constant; req_ready stays 0; the next grant occurs only after the handshake.
4. Timeout, ack phase: mul_done stuck at 1 with TMO=15 -> rsp_valid 17 cycles after ISSUE with rsp_err=1 and rsp_p=0; the next request is then served normally.
5. Timeout, done phase: done falls but never rises -> RESP with rsp_err=1 after TMO+1 cycles in WAIT_DONE.
6. Reset mid-op: assert rst for one cycle during WAIT_DONE -> next cycle busy=0, mul_st=0, rsp_valid=0; the next request with requester 0 valid is granted requester 0 (rr_ptr=0).
